univ_shift_reg: RTL and testbench

Parametrised successor to the team's 8-bit load/clear/shift-left register. Adds WIDTH generalisation, five shift/rotate modes, and multi-position shifts, one bit per clock. A start/busy/done handshake lets a controller request an N-position shift and wait for completion. Used as a serialiser/deserialiser and as the shift element in multi-cycle datapaths.

---
 rtl/shreg_pkg.sv | 25 ++
 rtl/univ_shift_reg_if.sv | 48 ++++
 rtl/shreg_step.sv | 34 +++
 rtl/univ_shift_reg.sv | 122 ++++++++++++
 tb/tb_univ_shift_reg.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/shreg_pkg.sv
// Shared types for the universal shift register.
//   op_e        : 3-bit shift/rotate operation code (values 5-7 reserved)
//   state_e     : control FSM state, also exported on the debug state signal
//   is_valid_op : true for the five implemented operation codes
package shreg_pkg;

  typedef enum logic [2:0] {
    SHL = 3'd0,
    SHR = 3'd1,
    ROL = 3'd2,
    ROR = 3'd3,
    ASR = 3'd4
  } op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  function automatic logic is_valid_op(input logic [2:0] m);
    return (m <= 3'd4);
  endfunction

endpackage

// File: rtl/univ_shift_reg_if.sv
// Controller-facing bus of the universal shift register.
// Optional macro: SHREG_PARITY_EN adds the par signal (^q).
//   master : controller side (drives clr/ld/d/start/mode/amt/sh_in)
//   slave  : register side   (drives q/sh_out/busy/done/state[/par])
// Handshake: a request (ld or start) is taken on any rising clock edge
// where busy is low; while busy is high requests are ignored. done
// pulses for exactly one cycle after the final shift edge. clr is taken
// on any edge and aborts without a done pulse.
interface univ_shift_reg_if #(parameter int WIDTH = 8);
  import shreg_pkg::*;

  localparam int CNT_W = $clog2(WIDTH) + 1;

  logic             clr;
  logic             ld;
  logic [WIDTH-1:0] d;
  logic             start;
  logic [2:0]       mode;
  logic [CNT_W-1:0] amt;
  logic             sh_in;
  logic [WIDTH-1:0] q;
  logic             sh_out;
  logic             busy;
  logic             done;
  state_e           state;   // debug view of the control FSM
`ifdef SHREG_PARITY_EN
  logic             par;

  modport master (
    output clr, ld, d, start, mode, amt, sh_in,
    input  q, sh_out, busy, done, state, par
  );
  modport slave (
    input  clr, ld, d, start, mode, amt, sh_in,
    output q, sh_out, busy, done, state, par
  );
`else
  modport master (
    output clr, ld, d, start, mode, amt, sh_in,
    input  q, sh_out, busy, done, state
  );
  modport slave (
    input  clr, ld, d, start, mode, amt, sh_in,
    output q, sh_out, busy, done, state
  );
`endif

endinterface

// File: rtl/shreg_step.sv
// Combinational one-position shifter/rotator.
//   q       : current register value
//   op      : operation to apply
//   sh_in   : serial fill bit (SHL/SHR only)
//   q_next  : value after one step
//   bit_out : bit shifted or rotated out by this step
module shreg_step
  import shreg_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] q,
  input  op_e              op,
  input  logic             sh_in,
  output logic [WIDTH-1:0] q_next,
  output logic             bit_out
);

  localparam int M = WIDTH - 1;

  always_comb begin
    q_next  = q;
    bit_out = 1'b0;
    case (op)
      SHL: begin q_next = {q[M-1:0], sh_in}; bit_out = q[M]; end
      SHR: begin q_next = {sh_in, q[M:1]};   bit_out = q[0]; end
      ROL: begin q_next = {q[M-1:0], q[M]};  bit_out = q[M]; end
      ROR: begin q_next = {q[0], q[M:1]};    bit_out = q[0]; end
      ASR: begin q_next = {q[M], q[M:1]};    bit_out = q[0]; end
      default: begin q_next = q; bit_out = 1'b0; end
    endcase
  end

endmodule

// File: rtl/univ_shift_reg.sv
// Universal shift register: parallel load, synchronous clear and
// multi-position shift/rotate (one position per clock) with a
// start/busy/done handshake.
// Optional macro: SHREG_PARITY_EN adds bus.par = ^q.
//   ck  : clock, rising edge
//   rst : asynchronous reset, active high
//   bus : univ_shift_reg_if slave modport (see interface header)
module univ_shift_reg
  import shreg_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input logic             ck,
  input logic             rst,
  univ_shift_reg_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  state_e           state_r;
  op_e              op_r;
  logic [CNT_W-1:0] cnt_r;
  logic [WIDTH-1:0] q_r;
  logic             sh_out_r;
  logic             busy_r;
  logic             done_r;

  logic [CNT_W-1:0] neff;
  op_e              op_sel;
  logic [WIDTH-1:0] step_q;
  logic             step_bit;

  // Requests longer than the register are clamped; rotate by WIDTH is
  // identity and SHL/SHR by WIDTH fills entirely with sh_in.
  assign neff = (bus.amt > CNT_W'(WIDTH)) ? CNT_W'(WIDTH) : bus.amt;

  // The single step unit serves both the start edge (mode from the bus)
  // and the following edges (latched mode).
  assign op_sel = (state_r == SHIFT) ? op_r : op_e'(bus.mode);

  shreg_step #(.WIDTH(WIDTH)) u_step (
    .q       (q_r),
    .op      (op_sel),
    .sh_in   (bus.sh_in),
    .q_next  (step_q),
    .bit_out (step_bit)
  );

  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      state_r  <= IDLE;
      op_r     <= SHL;
      cnt_r    <= '0;
      q_r      <= '0;
      sh_out_r <= 1'b0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
    end else if (bus.clr) begin
      state_r  <= IDLE;
      cnt_r    <= '0;
      q_r      <= '0;
      sh_out_r <= 1'b0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      case (state_r)
        IDLE, DONE: begin
          // DONE lasts one cycle but accepts requests exactly like IDLE.
          state_r <= IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
          if (bus.ld) begin
            q_r <= bus.d;
          end else if (bus.start && is_valid_op(bus.mode)) begin
            op_r <= op_e'(bus.mode);
            if (neff == '0) begin
              cnt_r   <= '0;
              state_r <= DONE;
              done_r  <= 1'b1;
            end else begin
              q_r      <= step_q;
              sh_out_r <= step_bit;
              cnt_r    <= neff - CNT_W'(1);
              if (neff == CNT_W'(1)) begin
                state_r <= DONE;
                done_r  <= 1'b1;
              end else begin
                state_r <= SHIFT;
                busy_r  <= 1'b1;
              end
            end
          end
        end
        SHIFT: begin
          q_r      <= step_q;
          sh_out_r <= step_bit;
          cnt_r    <= cnt_r - CNT_W'(1);
          if (cnt_r == CNT_W'(1)) begin
            state_r <= DONE;
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
          end
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.q      = q_r;
  assign bus.sh_out = sh_out_r;
  assign bus.busy   = busy_r;
  assign bus.done   = done_r;
  assign bus.state  = state_r;
`ifdef SHREG_PARITY_EN
  assign bus.par    = ^q_r;
`endif

endmodule

// File: tb/tb_univ_shift_reg.sv
module tb_univ_shift_reg;
  import shreg_pkg::*;

  logic ck;
  logic rst;
  int   checks;
  int   failures;

  univ_shift_reg_if #(.WIDTH(8)) bus ();

  univ_shift_reg #(.WIDTH(8)) dut (
    .ck  (ck),
    .rst (rst),
    .bus (bus.slave)
  );

  // clock / reset
  initial begin
    ck = 1'b0;
    forever #5 ck = ~ck;
  end

  // driver tasks
  task automatic tick();
    @(posedge ck);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_ld(input logic [7:0] v);
    bus.ld = 1'b1;
    bus.d  = v;
    tick();
    bus.ld = 1'b0;
  endtask

  task automatic start_op(input logic [2:0] m, input logic [3:0] a, input logic s);
    bus.start = 1'b1;
    bus.mode  = m;
    bus.amt   = a;
    bus.sh_in = s;
    tick();
    bus.start = 1'b0;
  endtask

  // Called right after the start edge; returns the number of sampled
  // busy cycles and edges until done, leaving time at the done cycle.
  task automatic wait_done(input string tag, output int bcnt, output int edges);
    bit seen;
    seen  = 1'b0;
    bcnt  = 0;
    edges = 0;
    for (int k = 0; k < 64; k++) begin
      if (bus.done) begin
        seen = 1'b1;
        break;
      end
      if (bus.busy) bcnt++;
      tick();
      edges++;
    end
    check({tag, "_done_seen"}, 32'(seen), 32'd1);
  endtask

  task automatic after_done(input string tag);
    tick();
    check({tag, "_done_pulse_len"}, 32'(bus.done), 32'd0);
    check({tag, "_idle"}, 32'(bus.state), 32'(IDLE));
  endtask

  int bcnt;
  int edges;
  int done_cnt;

  initial begin
    checks    = 0;
    failures  = 0;
    rst       = 1'b1;
    bus.clr   = 1'b0;
    bus.ld    = 1'b0;
    bus.d     = '0;
    bus.start = 1'b0;
    bus.mode  = '0;
    bus.amt   = '0;
    bus.sh_in = 1'b0;

    #7;
    check("rst_q",      32'(bus.q),      32'h0);
    check("rst_busy",   32'(bus.busy),   32'd0);
    check("rst_done",   32'(bus.done),   32'd0);
    check("rst_sh_out", 32'(bus.sh_out), 32'd0);
    check("rst_state",  32'(bus.state),  32'(IDLE));
    #1 rst = 1'b0;
    tick();

    // single-position SHL
    do_ld(8'b1011_0001);
    check("ld_q", 32'(bus.q), 32'hB1);
    start_op(3'(SHL), 4'd1, 1'b1);
    wait_done("shl1", bcnt, edges);
    check("shl1_busy",   32'(bcnt),       32'd0);
    check("shl1_lat",    32'(edges),      32'd0);
    check("shl1_q",      32'(bus.q),      32'h63);
    check("shl1_sh_out", 32'(bus.sh_out), 32'd1);
    after_done("shl1");

    // multi-position ROR
    do_ld(8'b1000_0001);
    start_op(3'(ROR), 4'd3, 1'b0);
    check("ror3_busy_e0", 32'(bus.busy), 32'd1);
    wait_done("ror3", bcnt, edges);
    check("ror3_busy",   32'(bcnt),       32'd2);
    check("ror3_lat",    32'(edges),      32'd2);
    check("ror3_q",      32'(bus.q),      32'h30);
    check("ror3_sh_out", 32'(bus.sh_out), 32'd0);
    after_done("ror3");

    // clamped ASR
    do_ld(8'b1001_0000);
    start_op(3'(ASR), 4'd12, 1'b0);
    wait_done("asr12", bcnt, edges);
    check("asr12_busy",   32'(bcnt),       32'd7);
    check("asr12_q",      32'(bus.q),      32'hFF);
    check("asr12_sh_out", 32'(bus.sh_out), 32'd1);
    after_done("asr12");

    // rotate by WIDTH is identity
    do_ld(8'hA5);
    start_op(3'(ROL), 4'd8, 1'b0);
    wait_done("rol8", bcnt, edges);
    check("rol8_busy",   32'(bcnt),       32'd7);
    check("rol8_q",      32'(bus.q),      32'hA5);
    check("rol8_sh_out", 32'(bus.sh_out), 32'd1);
    after_done("rol8");

    // SHR by WIDTH fills with sh_in
    do_ld(8'h3C);
    start_op(3'(SHR), 4'd8, 1'b1);
    wait_done("shr8", bcnt, edges);
    check("shr8_q",      32'(bus.q),      32'hFF);
    check("shr8_sh_out", 32'(bus.sh_out), 32'd0);
    after_done("shr8");

    // abort and ld protection while busy
    do_ld(8'hFF);
    start_op(3'(SHL), 4'd5, 1'b0);
    check("abort_q_e0", 32'(bus.q), 32'hFE);
    bus.ld = 1'b1;
    bus.d  = 8'h00;
    tick();
    bus.ld = 1'b0;
    check("abort_ld_ignored", 32'(bus.q),    32'hFC);
    check("abort_busy_mid",   32'(bus.busy), 32'd1);
    bus.clr = 1'b1;
    tick();
    bus.clr = 1'b0;
    check("abort_q",      32'(bus.q),      32'h0);
    check("abort_busy",   32'(bus.busy),   32'd0);
    check("abort_done",   32'(bus.done),   32'd0);
    check("abort_sh_out", 32'(bus.sh_out), 32'd0);
    check("abort_state",  32'(bus.state),  32'(IDLE));
    tick();
    check("abort_no_done", 32'(bus.done), 32'd0);

    // amt=0 and reserved mode
    do_ld(8'h5A);
    start_op(3'(SHL), 4'd0, 1'b1);
    check("amt0_done", 32'(bus.done), 32'd1);
    check("amt0_busy", 32'(bus.busy), 32'd0);
    check("amt0_q",    32'(bus.q),    32'h5A);
    after_done("amt0");
    start_op(3'd5, 4'd3, 1'b1);
    check("rsv_q",     32'(bus.q),     32'h5A);
    check("rsv_done",  32'(bus.done),  32'd0);
    check("rsv_busy",  32'(bus.busy),  32'd0);
    check("rsv_state", 32'(bus.state), 32'(IDLE));
    tick();
    check("rsv_no_done", 32'(bus.done), 32'd0);

    // ld wins over start
    bus.start = 1'b1;
    bus.mode  = 3'(SHL);
    bus.amt   = 4'd1;
    do_ld(8'h0F);
    bus.start = 1'b0;
    check("ldwin_q",    32'(bus.q),    32'h0F);
    check("ldwin_done", 32'(bus.done), 32'd0);

    // asynchronous reset mid-shift
    do_ld(8'h01);
    start_op(3'(SHL), 4'd5, 1'b1);
    check("arst_q_e0", 32'(bus.q), 32'h03);
    tick();
    #3 rst = 1'b1;
    #1;
    check("arst_q",      32'(bus.q),      32'h0);
    check("arst_busy",   32'(bus.busy),   32'd0);
    check("arst_done",   32'(bus.done),   32'd0);
    check("arst_sh_out", 32'(bus.sh_out), 32'd0);
    #1 rst = 1'b0;
    done_cnt = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (bus.done) done_cnt++;
    end
    check("arst_no_done", 32'(done_cnt),  32'd0);
    check("arst_idle",    32'(bus.state), 32'(IDLE));

`ifdef SHREG_PARITY_EN
    do_ld(8'b0000_0111);
    check("par_odd", 32'(bus.par), 32'd1);
    do_ld(8'b0000_0011);
    check("par_even", 32'(bus.par), 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
